// File: rtl/scan_decoder.sv
// PS/2 scan-code decoder: E0/F0 prefix FSM with idle timeout,
// first-word-fall-through event FIFO, held-key display and error pulse.
module scan_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  ev_code,
  output logic        ev_ext,
  output logic        ev_brk,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [15:0] disp_code,
  output logic        overflow,
  output logic        err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  ev_t           mem_q [FIFO_DEPTH];
  ev_t           mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   disp_q, disp_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  logic          is_e0, is_f0, is_bad;
  logic          emit;
  ev_t           ev_new;
  logic          full, pop, push, drop;
  logic [15:0]   key;

  assign is_e0  = (rx_data == 8'hE0);
  assign is_f0  = (rx_data == 8'hF0);
  assign is_bad = (rx_data == 8'h00) || (rx_data == 8'hFF);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    err_d       = 1'b0;
    emit        = 1'b0;
    ev_new.ext  = 1'b0;
    ev_new.brk  = 1'b0;
    ev_new.code = rx_data;
    if (rx_valid) begin
      wait_d = '0;
      if (is_bad) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            unique case (1'b1)
              is_e0:   state_d = GOT_E0;
              is_f0:   state_d = GOT_F0;
              default: emit = 1'b1;
            endcase
          end
          GOT_E0: begin
            unique case (1'b1)
              is_e0:   state_d = GOT_E0;
              is_f0:   state_d = GOT_E0F0;
              default: begin
                emit       = 1'b1;
                ev_new.ext = 1'b1;
                state_d    = IDLE;
              end
            endcase
          end
          GOT_F0: begin
            unique case (1'b1)
              is_f0:   state_d = GOT_F0;
              is_e0:   state_d = GOT_E0F0;
              default: begin
                emit       = 1'b1;
                ev_new.brk = 1'b1;
                state_d    = IDLE;
              end
            endcase
          end
          default: begin
            if (is_e0 || is_f0) begin
              state_d = GOT_E0F0;
            end else begin
              emit       = 1'b1;
              ev_new.ext = 1'b1;
              ev_new.brk = 1'b1;
              state_d    = IDLE;
            end
          end
        endcase
      end
    end else if (state_q != IDLE) begin
      // abandon a prefix whose follow-up byte never arrived
      if (wait_q == CW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        wait_d  = '0;
      end else begin
        wait_d = wait_q + CW'(1);
      end
    end else begin
      wait_d = '0;
    end
  end

  assign ev_valid = (cnt_q != '0);
  assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop      = ev_valid && ev_ready;
  assign push     = emit && (!full || pop);
  assign drop     = emit && full && !pop;
  assign key      = {ev_new.ext ? 8'hE0 : 8'h00, rx_data};

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_q] = ev_new;
    end
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d = ovf_q | drop;
    disp_d = disp_q;
    if (emit) begin
      if (!ev_new.brk) begin
        disp_d = key;
      end else if (key == disp_q) begin
        disp_d = 16'h0000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign ev_code   = mem_q[rd_q].code;
  assign ev_ext    = mem_q[rd_q].ext;
  assign ev_brk    = mem_q[rd_q].brk;
  assign disp_code = disp_q;
  assign overflow  = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: prefixes, FIFO fill/drain,
// overflow, timeout, error bytes and mid-sequence reset.
module tb_scan_decoder;

  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  ev_code;
  logic        ev_ext;
  logic        ev_brk;
  logic        ev_valid;
  logic        ev_ready;
  logic [15:0] disp_code;
  logic        overflow;
  logic        err;

  int total;
  int bad;
  int err_cnt;
  logic [9:0] got [$];

  scan_decoder #(
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_brk   (ev_brk),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .disp_code(disp_code),
    .overflow (overflow),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // popped events recorded as {ext, brk, code}
  always @(negedge clk) begin
    if (ev_valid && ev_ready) got.push_back({ev_ext, ev_brk, ev_code});
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] ev_at(input int i);
    return (got.size() > i) ? got[i] : 10'h3FF;
  endfunction

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #2;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    settle(2);
    rst_n = 1'b1;
    got.delete();
    err_cnt = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_valid"}, ev_valid, 0);
    check({tag, "_code"}, ev_code, 0);
    check({tag, "_ext"}, ev_ext, 0);
    check({tag, "_brk"}, ev_brk, 0);
    check({tag, "_disp"}, disp_code, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    err_cnt  = 0;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    ev_ready = 1'b0;
    settle(2);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    settle(1);

    // make then break of 1C
    ev_ready = 1'b1;
    send(8'h1C);
    check("disp_1c", disp_code, 16'h001C);
    send(8'hF0);
    send(8'h1C);
    settle(3);
    check("disp_1c_clr", disp_code, 16'h0000);
    check("n_1c", got.size(), 2);
    check("ev0_1c", ev_at(0), 10'h01C);
    check("ev1_1c", ev_at(1), 10'h11C);

    // extended make/break
    got.delete();
    send(8'hE0);
    send(8'h75);
    check("disp_e075", disp_code, 16'hE075);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    settle(3);
    check("disp_e075_clr", disp_code, 16'h0000);
    check("n_ext", got.size(), 2);
    check("ev0_ext", ev_at(0), 10'h275);
    check("ev1_ext", ev_at(1), 10'h375);

    // fill, overflow, held head, then drain
    got.delete();
    ev_ready = 1'b0;
    send(8'h1C);
    send(8'h32);
    send(8'h21);
    send(8'h23);
    check("ovf_before", overflow, 0);
    send(8'h24);
    check("ovf_set", overflow, 1);
    check("disp_24", disp_code, 16'h0024);
    check("head_valid", ev_valid, 1);
    check("head_code", ev_code, 8'h1C);
    settle(3);
    check("head_hold", {ev_ext, ev_brk, ev_code}, 10'h01C);
    ev_ready = 1'b1;
    settle(6);
    check("n_drain", got.size(), 4);
    check("dr0", ev_at(0), 10'h01C);
    check("dr1", ev_at(1), 10'h032);
    check("dr2", ev_at(2), 10'h021);
    check("dr3", ev_at(3), 10'h023);
    check("drain_empty", ev_valid, 0);
    check("ovf_sticky", overflow, 1);

    // timeout boundary: one cycle short still breaks
    do_reset();
    check("ovf_rst", overflow, 0);
    ev_ready = 1'b1;
    send(8'hF0);
    settle(TO - 2);
    send(8'h1C);
    settle(3);
    check("n_to_short", got.size(), 1);
    check("to_short", ev_at(0), 10'h11C);
    got.delete();
    send(8'hF0);
    settle(TO - 1);
    send(8'h1C);
    settle(3);
    check("n_to_full", got.size(), 1);
    check("to_full", ev_at(0), 10'h01C);
    check("disp_to", disp_code, 16'h001C);

    // error byte after prefix
    got.delete();
    err_cnt = 0;
    send(8'hE0);
    send(8'hFF);
    settle(3);
    check("err_pulse", err_cnt, 1);
    check("err_noev", got.size(), 0);
    send(8'h1C);
    settle(3);
    check("err_next", ev_at(0), 10'h01C);
    check("err_cnt_end", err_cnt, 1);

    // push and pop together on a full FIFO
    do_reset();
    ev_ready = 1'b0;
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    @(posedge clk);
    #2;
    rx_data  = 8'h35;
    rx_valid = 1'b1;
    ev_ready = 1'b1;
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
    ev_ready = 1'b0;
    check("full_ovf", overflow, 0);
    check("full_head", ev_code, 8'h1D);
    check("full_pop", ev_at(0), 10'h015);
    ev_ready = 1'b1;
    settle(6);
    check("n_full", got.size(), 5);
    check("fl1", ev_at(1), 10'h01D);
    check("fl2", ev_at(2), 10'h024);
    check("fl3", ev_at(3), 10'h02D);
    check("fl4", ev_at(4), 10'h035);
    check("full_ovf_end", overflow, 0);

    // reset mid-prefix with FIFO occupied
    ev_ready = 1'b0;
    send(8'h1C);
    send(8'hE0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    settle(1);
    rst_n = 1'b1;
    got.delete();
    ev_ready = 1'b1;
    send(8'h75);
    settle(3);
    check("n_mid", got.size(), 1);
    check("mid_ev", ev_at(0), 10'h075);
    check("mid_disp", disp_code, 16'h0075);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 100000, clk cycles a pending prefix may wait for its next byte.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 rx_data  input  8  received PS/2 scan-code byte from the upstream frame receiver.
REQ-006 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 ev_code  output  8  head-of-FIFO key code, prefixes stripped.
REQ-008 ev_ext  output  1  head event carried an E0 prefix.
REQ-009 ev_brk  output  1  head event is a release (F0 prefix).
REQ-010 ev_valid  output  1  FIFO non-empty; head fields valid.
REQ-011 ev_ready  input  1  consumer accepts head when high with ev_valid.
REQ-012 disp_code  output  16  last held key for the hex display: {8'hE0 or 8'h00, code}.
REQ-013 overflow  output  1  sticky: an event was dropped on a full FIFO.
REQ-014 err  output  1  one-cycle pulse: byte 8'h00 or 8'hFF received.

Function
REQ-015 Prefix FSM SHALL have states IDLE, GOT_E0, GOT_F0, GOT_E0F0, evaluated only on cycles with rx_valid=1.
REQ-016 IDLE: E0 -> GOT_E0; F0 -> GOT_F0; other code -> emit make, ext=0, stay IDLE.
REQ-017 GOT_E0: E0 -> stay; F0 -> GOT_E0F0; other -> emit make, ext=1, -> IDLE.
REQ-018 GOT_F0: F0 -> stay; E0 -> GOT_E0F0; other -> emit break, ext=0, -> IDLE.
REQ-019 GOT_E0F0: E0 or F0 -> stay; other -> emit break, ext=1, -> IDLE.
REQ-020 Bytes 8'h00 and 8'hFF in any state SHALL emit nothing, pulse err the next cycle, and force IDLE.
REQ-021 In any non-IDLE state, a free-running wait counter SHALL return the FSM to IDLE after TIMEOUT consecutive cycles without rx_valid; counter clears on every rx_valid and in IDLE; no event, no err.
REQ-022 Emitted event SHALL be pushed to the FIFO on the cycle after the rx_valid that completed it; with an empty FIFO ev_valid rises in that same cycle (one-cycle latency, registered).
REQ-023 FIFO SHALL be first-word-fall-through; pop occurs on a cycle with ev_valid=1 and ev_ready=1.
REQ-024 Push on full FIFO with no pop SHALL drop the new event and set overflow; overflow clears only on reset.
REQ-025 Simultaneous push and pop on full FIFO SHALL accept the push (no overflow); simultaneous push and pop on empty SHALL NOT occur, since ev_valid=0.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-027 disp_code SHALL update when an event is emitted, independent of FIFO acceptance: make -> {ext?8'hE0:8'h00, code}; break whose {ext,code} equals disp_code -> 16'h0000; break of a different key -> unchanged.
REQ-028 ev_code/ev_ext/ev_brk SHALL be held stable while ev_valid=1 and ev_ready=0.

Reset
REQ-029 rst_n=0 SHALL immediately force: FSM IDLE, wait counter 0, FIFO empty, ev_valid=0, ev_code=8'h00, ev_ext=0, ev_brk=0, disp_code=16'h0000, overflow=0, err=0.
REQ-030 Reset mid-sequence (prefix pending or FIFO occupied) SHALL discard all pending state; the first byte after release SHALL be decoded from IDLE.

Verification
REQ-031 Bytes 1C, F0, 1C, ev_ready=1 -> events {1C,ext0,brk0} then {1C,ext0,brk1}; disp_code 001C, then 0000.
REQ-032 Bytes E0, 75, E0, F0, 75 -> events {75,1,0}, {75,1,1}; disp_code E075, then 0000.
REQ-033 ev_ready=0, bytes 1C,32,21,23,24 with FIFO_DEPTH=4 -> four events held, 24 dropped, overflow=1, disp_code 0024; then ev_ready=1 drains 1C,32,21,23 in order.
REQ-034 Byte F0, then TIMEOUT idle cycles, then 1C -> make {1C,0,0}; no break emitted.
REQ-035 Byte E0 then FF -> err pulses one cycle, no event, next byte 1C decoded as make ext=0.
REQ-036 Full FIFO, ev_ready=1 with new event in same cycle -> occupancy stays 4, overflow stays 0; rst_n low mid-prefix -> all outputs at reset values.
